mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one `multiplier` instance (any MUL_TYPE) between N requesters, e.g. synth voices needing envelope × sample products.
- Arbitrates requests round-robin and latches the winner's operands.
- Runs the multiplier's trigger/ready/done handshake and returns the product to the winner with a one-cycle valid strobe.
- Sits between the voice datapaths and the shared multiplier on the control clock.

Parameters:
- C_WIDTH, 8, operand width; product is 2*C_WIDTH.
- N_REQ, 4, number of requesters (2..16).
- REQ_IDX_W, $clog2(N_REQ), width of the winner index; derived, not overridden.

Ports:
- ctl_clk  in  1  control clock; everything is on its rising edge.
- reset  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held until the matching ack.
- req_a  in  N_REQ*C_WIDTH  operand a, requester i at bits [i*C_WIDTH +: C_WIDTH].
- req_b  in  N_REQ*C_WIDTH  operand b, same packing.
- req_ack  out  N_REQ  one-hot, one-cycle pulse when requester's operands are latched.
- resp_valid  out  N_REQ  one-hot, one-cycle pulse when resp_y belongs to that requester.
- resp_y  out  2*C_WIDTH  product; held until the next response.
- busy  out  1  high in every state except IDLE.
- mul_a  out  C_WIDTH  operand a to the multiplier (registered).
- mul_b  out  C_WIDTH  operand b to the multiplier (registered).
- mul_trigger  out  1  one-cycle start pulse to the multiplier.
- mul_ready  in  1  multiplier can accept a trigger.
- mul_done  in  1  multiplier result valid (pulse).
- mul_y  in  2*C_WIDTH  multiplier product.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs 0: req_ack, resp_valid, resp_y, busy, mul_a, mul_b, mul_trigger.
  - RR pointer to 0; winner index to 0.
  - Reset mid-operation abandons the product; a late mul_done after reset release is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req bit is set and mul_ready=1: pick the winner, the first set bit scanning upward from the RR pointer with wrap N_REQ-1→0.
  - Latch that requester's req_a/req_b into mul_a/mul_b and its index into the winner register.
  - Pulse req_ack[winner] and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mul_trigger=1 for exactly this cycle; go to WAIT.
  - mul_a/mul_b stay stable from latch until the next latch.
- WAIT:
  - On mul_done=1: resp_y<=mul_y, resp_valid[winner] pulses the next cycle, RR pointer <= (winner+1) mod N_REQ, go to IDLE.
  - No timeout; the block stays in WAIT until mul_done.
- Latency:
  - req seen in IDLE → req_ack next edge.
  - mul_trigger one cycle after req_ack.
  - resp_valid one cycle after mul_done.
- Back-to-back: a requester may re-assert or keep req after its ack; it is eligible again only after the pointer passes it, so there is no starvation.
- req dropped before ack: that request is not served; no ack or response is issued.
- Simultaneous mul_done and new req in WAIT: the response is completed first; the new arbitration happens in the following IDLE cycle.
- mul_done seen in IDLE or ISSUE: ignored.
- Arithmetic: no processing; resp_y = mul_y bit-exact, with fixed-point handling left to the multiplier.
- req_ack and resp_valid are always one-hot or zero.

Optional Feature:
- Macro: MUL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins, pointer logic removed; requester 0 can starve the others.
- Undefined (default): round-robin as above.
- Ports and timing are identical either way.

Decomposition:
- Shared package `mul_arb_pkg`:
  - state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - helper function for operand-slice extraction.
- Sub-module `mul_arb_pick` (combinational):
  - inputs: req, pointer.
  - outputs: any, winner index, one-hot grant.
  - fixed-priority variant selected by the macro.

Test Plan (C_WIDTH=8, N_REQ=4; real `multiplier` MUL_TYPE=0 plus a stub with configurable done delay):
- Single request: req=4'b0010, a=8'h03, b=8'h02 → ack[1] next cycle, trigger one cycle later, after done resp_valid=4'b0010 with resp_y=16'h0006.
- RR fairness: req=4'b1111 held with operands i+1 × 2 → responses in order 0,1,2,3,0 with resp_y=2,4,6,8,2; re-check with MUL_ARB_FIXED_PRIO_EN → always requester 0.
- Pointer wrap: pointer at 3, req=4'b1001 → requester 3 served first, then 0; a=8'h24, b=8'h70 gives resp_y=16'h0FC0.
- mul_ready=0 with req pending → no ack, no trigger, busy=0; ack within 1 cycle of mul_ready rising.
- Reset mid-WAIT: drop reset two cycles after trigger → all outputs 0 immediately; stub's later done ignored; a fresh request afterwards completes correctly.
- Withdrawn request: req[2] pulses for one cycle while busy → never acked, no resp_valid[2].

Source files
------------

// File: rtl/mul_arb_pkg.sv
// +----------------------------------------------------------------------------
// | mul_arb_pkg : shared types and helpers for the multiplier arbiter
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Widest operand and widest packed operand bus the slice helper handles.
  localparam int MAX_OP_W  = 64;
  localparam int MAX_BUS_W = 1024;

  function automatic logic [MAX_OP_W-1:0] op_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          width
  );
    return MAX_OP_W'(bus >> (idx * width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_arb_pick.sv
// +----------------------------------------------------------------------------
// | mul_arb_pick : combinational winner selection (round-robin from ptr, or
// |                lowest index first when MUL_ARB_FIXED_PRIO_EN is defined)
// | Revision     : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mul_arb_pick #(
  parameter  int N_REQ     = 4,
  localparam int REQ_IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]     req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic                 any,
  output logic [REQ_IDX_W-1:0] idx,
  output logic [N_REQ-1:0]     grant
);

`ifdef MUL_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[REQ_IDX_W'(i)]) begin
        any = 1'b1;
        idx = REQ_IDX_W'(i);
      end
    end
  end
`else
  // Scan downward in offset so the smallest offset from ptr wins last.
  always_comb begin
    int cand;
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req[REQ_IDX_W'(cand)]) begin
        any = 1'b1;
        idx = REQ_IDX_W'(cand);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/mul_arbiter.sv
// +----------------------------------------------------------------------------
// | mul_arbiter : shares one multiplier between N_REQ requesters and runs its
// |               trigger/done handshake. Option: MUL_ARB_FIXED_PRIO_EN.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int C_WIDTH   = 8,
  parameter  int N_REQ     = 4,
  localparam int REQ_IDX_W = $clog2(N_REQ)
) (
  input  logic                     ctl_clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*C_WIDTH-1:0] req_a,
  input  logic [N_REQ*C_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [2*C_WIDTH-1:0]     resp_y,
  output logic                     busy,
  output logic [C_WIDTH-1:0]       mul_a,
  output logic [C_WIDTH-1:0]       mul_b,
  output logic                     mul_trigger,
  input  logic                     mul_ready,
  input  logic                     mul_done,
  input  logic [2*C_WIDTH-1:0]     mul_y
);

  arb_state_t           state, state_nx;
  logic [REQ_IDX_W-1:0] winner;
  logic [REQ_IDX_W-1:0] ptr;
  logic                 pick_any;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0]     pick_grant;
  logic                 launch;
  logic                 complete;

  mul_arb_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .any   (pick_any),
    .idx   (pick_idx),
    .grant (pick_grant)
  );

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && mul_ready) begin
          launch   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (mul_done) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      winner      <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      req_ack     <= '0;
      mul_trigger <= 1'b0;
      resp_valid  <= '0;
      resp_y      <= '0;
    end else begin
      if (launch) begin
        winner <= pick_idx;
        mul_a  <= C_WIDTH'(op_slice(MAX_BUS_W'(req_a), 32'(pick_idx), C_WIDTH));
        mul_b  <= C_WIDTH'(op_slice(MAX_BUS_W'(req_b), 32'(pick_idx), C_WIDTH));
      end
      req_ack     <= launch ? pick_grant : '0;
      // Trigger trails the ack by one cycle, i.e. it is high in the first WAIT cycle.
      mul_trigger <= (state == ISSUE);
      resp_valid  <= complete ? (N_REQ'(1) << winner) : '0;
      if (complete) resp_y <= mul_y;
    end
  end

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset)        ptr <= '0;
    else if (complete) ptr <= (winner == REQ_IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: table vectors, corner sequences and randomized traffic
// against a transaction-level reference model with a multiplier stub.
`default_nettype none

module tb_mul_arbiter;

  localparam int CW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] req_a = '0;
  logic [N*CW-1:0] req_b = '0;
  logic [N-1:0]    req_ack, resp_valid;
  logic [2*CW-1:0] resp_y;
  logic            busy;
  logic [CW-1:0]   mul_a, mul_b;
  logic            mul_trigger;
  logic            mul_ready = 1'b1;
  logic            mul_done = 1'b0;
  logic [2*CW-1:0] mul_y = '0;

  mul_arbiter #(.C_WIDTH(CW), .N_REQ(N)) dut (
    .ctl_clk(clk), .reset(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_y(resp_y), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_trigger(mul_trigger),
    .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier stub ----------------
  int              stub_cnt = -1;
  int              stub_dly = 1;
  logic [2*CW-1:0] stub_prod = '0;
  bit              ready_en = 1'b1;

  task automatic set_ready();
    mul_ready = ready_en && (stub_cnt < 0);
  endtask

  task automatic stub_step();
    mul_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        mul_done = 1'b1;
        mul_y    = stub_prod;
        stub_cnt = -1;
      end
    end
    if (mul_trigger && stub_cnt < 0) begin
      stub_prod = 16'(mul_a) * 16'(mul_b);
      stub_cnt  = stub_dly;
    end
    set_ready();
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; logic [2*CW-1:0] y; } exp_t;
  exp_t            expq[$];
  int              m_ptr = 0;
  bit              outstanding = 1'b0;
  bit              prev_ack_any = 1'b0;
  logic [N-1:0]    prev_req = '0;
  logic            prev_ready = 1'b0;
  logic [N*CW-1:0] prev_a = '0, prev_b = '0;

  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    int start;
`ifdef MUL_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic monitor();
    logic [N-1:0] exp_ack;
    exp_t e;
    int w;
    if (!rst_n) begin
      expq.delete();
      outstanding  = 1'b0;
      m_ptr        = 0;
      prev_ack_any = 1'b0;
      return;
    end
    exp_ack = '0;
    if (!outstanding && prev_req != '0 && prev_ready) begin
      w = ref_pick(prev_req, m_ptr);
      exp_ack[w] = 1'b1;
      e.idx = w;
      e.y   = 16'(prev_a[w*CW +: CW]) * 16'(prev_b[w*CW +: CW]);
      expq.push_back(e);
      outstanding = 1'b1;
    end
    check("ack", req_ack, exp_ack);
    check("trigger", mul_trigger, prev_ack_any);
    prev_ack_any = (req_ack != '0);
    if (resp_valid != '0) begin
      if (expq.size() == 0) begin
        check("resp_unexpected", resp_valid, '0);
      end else begin
        e = expq.pop_front();
        check("resp_valid", resp_valid, N'(1) << e.idx);
        check("resp_y", resp_y, e.y);
        m_ptr = (e.idx + 1) % N;
        outstanding = 1'b0;
      end
    end
    check("busy", busy, outstanding);
  endtask

  task automatic cyc();
    prev_req   = req;
    prev_ready = mul_ready;
    prev_a     = req_a;
    prev_b     = req_b;
    @(negedge clk);
    monitor();
    stub_step();
  endtask

  task automatic set_ops(input int i, input logic [CW-1:0] a, input logic [CW-1:0] b);
    req_a[i*CW +: CW] = a;
    req_b[i*CW +: CW] = b;
  endtask

  // ---------------- response collector ----------------
  int              got_n;
  int              ack_cyc;
  logic [N-1:0]    got_v[8];
  logic [2*CW-1:0] got_y[8];
  logic [CW-1:0]   got_a[8], got_b[8];

  task automatic collect(input int n, input bit drop_on_ack, input int budget);
    int c, na;
    got_n = 0; na = 0; c = 0; ack_cyc = -1;
    while (got_n < n && c < budget) begin
      cyc();
      c++;
      if (req_ack != '0) begin
        if (ack_cyc < 0) ack_cyc = c;
        if (na < 8) begin got_a[na] = mul_a; got_b[na] = mul_b; end
        na++;
        if (drop_on_ack) req = req & ~req_ack;
      end
      if (resp_valid != '0) begin
        got_v[got_n] = resp_valid;
        got_y[got_n] = resp_y;
        got_n++;
      end
    end
    check("collect_count", got_n, n);
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [CW-1:0]   a;
    logic [CW-1:0]   b;
    int              dly;
    logic [2*CW-1:0] y;
  } vec_t;

  vec_t vt[5];
  int   fair_idx[5];
  int   wrap_idx[2];
  logic [2*CW-1:0] wrap_y[2];

  initial begin
    int cnt0, cnt2, bad;
    logic [2*CW-1:0] y_hold;

    vt[0] = '{4'b0010, 8'h03, 8'h02, 1, 16'h0006};
    vt[1] = '{4'b0001, 8'hFF, 8'hFF, 2, 16'hFE01};
    vt[2] = '{4'b1000, 8'h24, 8'h70, 3, 16'h0FC0};
    vt[3] = '{4'b0100, 8'h00, 8'h5A, 1, 16'h0000};
    vt[4] = '{4'b0100, 8'h80, 8'h02, 4, 16'h0100};
`ifdef MUL_ARB_FIXED_PRIO_EN
    fair_idx = '{0, 0, 0, 0, 0};
    wrap_idx = '{0, 3};
    wrap_y   = '{16'h0023, 16'h0FC0};
`else
    fair_idx = '{0, 1, 2, 3, 0};
    wrap_idx = '{3, 0};
    wrap_y   = '{16'h0FC0, 16'h0023};
`endif

    // Reset state
    repeat (3) cyc();
    check("rst_ack", req_ack, '0);
    check("rst_resp_valid", resp_valid, '0);
    check("rst_resp_y", resp_y, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
    check("rst_trigger", mul_trigger, 1'b0);
    rst_n = 1'b1;

    // Round-robin fairness with all requesters held
    for (int i = 0; i < N; i++) set_ops(i, CW'(i + 1), 8'h02);
    req = 4'b1111;
    collect(5, 1'b0, 200);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      check("fair_valid", got_v[k], N'(1) << fair_idx[k]);
      check("fair_y", got_y[k], 16'(2 * (fair_idx[k] + 1)));
    end
    repeat (2) cyc();

    // Table of single requests
    for (int i = 0; i < 5; i++) begin
      stub_dly = vt[i].dly;
      for (int j = 0; j < N; j++)
        if (vt[i].req[j]) set_ops(j, vt[i].a, vt[i].b);
      req = vt[i].req;
      collect(1, 1'b1, 50);
      check("tbl_ack_latency", ack_cyc, 1);
      check("tbl_mul_a", got_a[0], vt[i].a);
      check("tbl_mul_b", got_b[0], vt[i].b);
      check("tbl_valid", got_v[0], vt[i].req);
      check("tbl_y", got_y[0], vt[i].y);
    end

    // Pointer wrap: serve 2 alone (pointer -> 3), then 3 and 0 together
    stub_dly = 2;
    set_ops(2, 8'h01, 8'h01);
    req = 4'b0100;
    collect(1, 1'b1, 50);
    set_ops(3, 8'h24, 8'h70);
    set_ops(0, 8'h05, 8'h07);
    req = 4'b1001;
    collect(2, 1'b1, 100);
    for (int k = 0; k < 2; k++) begin
      check("wrap_valid", got_v[k], N'(1) << wrap_idx[k]);
      check("wrap_y", got_y[k], wrap_y[k]);
    end

    // Multiplier not ready: request must wait, then ack one cycle after ready
    ready_en = 1'b0;
    set_ready();
    set_ops(2, 8'h11, 8'h03);
    req = 4'b0100;
    repeat (4) begin
      cyc();
      check("nready_ack", req_ack, '0);
      check("nready_trigger", mul_trigger, 1'b0);
      check("nready_busy", busy, 1'b0);
    end
    ready_en = 1'b1;
    set_ready();
    collect(1, 1'b1, 50);
    check("ready_ack_latency", ack_cyc, 1);
    check("ready_y", got_y[0], 16'h0033);

    // mul_done while idle is ignored
    y_hold = resp_y;
    mul_done = 1'b1;
    mul_y = 16'hBEEF;
    repeat (2) begin
      cyc();
      check("idle_done_valid", resp_valid, '0);
      check("idle_done_y", resp_y, y_hold);
    end

    // Reset mid-WAIT
    stub_dly = 8;
    set_ops(0, 8'h0B, 8'h03);
    req = 4'b0001;
    bad = 0;
    while (!mul_trigger && bad < 20) begin
      cyc();
      if (req_ack != '0) req = '0;
      bad++;
    end
    check("rstw_trigger_seen", mul_trigger, 1'b1);
    repeat (2) cyc();
    rst_n = 1'b0;
    req = '0;
    #1;
    check("rstw_ack", req_ack, '0);
    check("rstw_valid", resp_valid, '0);
    check("rstw_y", resp_y, '0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_mul_a", mul_a, '0);
    check("rstw_mul_b", mul_b, '0);
    check("rstw_trigger", mul_trigger, 1'b0);
    repeat (2) cyc();
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      cyc();
      if (resp_valid != '0 || busy) bad++;
    end
    check("rstw_late_done_ignored", bad, 0);
    stub_dly = 1;
    set_ops(1, 8'h07, 8'h09);
    req = 4'b0010;
    collect(1, 1'b1, 50);
    check("rstw_fresh_valid", got_v[0], 4'b0010);
    check("rstw_fresh_y", got_y[0], 16'h003F);

    // Withdrawn request while busy
    stub_dly = 4;
    set_ops(0, 8'h02, 8'h03);
    req = 4'b0001;
    cnt0 = 0; cnt2 = 0; bad = 0;
    while (req_ack == '0 && bad < 10) begin cyc(); bad++; end
    req = 4'b0100;
    set_ops(2, 8'h55, 8'h55);
    cyc();
    if (req_ack[2] || resp_valid[2]) cnt2++;
    req = '0;
    repeat (15) begin
      cyc();
      if (req_ack[2] || resp_valid[2]) cnt2++;
      if (resp_valid[0]) cnt0++;
    end
    check("withdraw_no_serve", cnt2, 0);
    check("withdraw_other_resp", cnt0, 1);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      cyc();
      ready_en = ($urandom_range(0, 7) != 0);
      stub_dly = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          set_ops(i, CW'($urandom), CW'($urandom));
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            set_ops(i, CW'($urandom), CW'($urandom));
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      set_ready();
    end
    req = '0;
    ready_en = 1'b1;
    set_ready();
    bad = 0;
    while ((expq.size() != 0 || busy) && bad < 100) begin cyc(); bad++; end
    check("drain_queue", expq.size(), 0);
    check("drain_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
